// File: rtl/dds_wave_gen_pkg.sv
// Shared definitions for the DDS waveform generator.
//   - wave_sel encodings (WAVE_SINE .. WAVE_DC; codes 4..7 all give DC)
//   - UNITY_GAMP : amp code giving unity gain (amp/128)
//   - MID_CODE   : unsigned DAC mid-scale code
//   - sat_u8     : clamp a signed intermediate to the 0..255 DAC range
package dds_wave_gen_pkg;

    localparam logic [2:0] WAVE_SINE   = 3'd0;
    localparam logic [2:0] WAVE_SQUARE = 3'd1;
    localparam logic [2:0] WAVE_TRI    = 3'd2;
    localparam logic [2:0] WAVE_SAW    = 3'd3;
    localparam logic [2:0] WAVE_DC     = 3'd4;

    localparam logic [7:0] UNITY_GAMP  = 8'd128;
    localparam logic [7:0] MID_CODE    = 8'd128;

    function automatic logic [7:0] sat_u8(input logic signed [16:0] v);
        if (v < 17'sd0) begin
            return 8'd0;
        end else if (v > 17'sd255) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/dds_wave_gen_sine_qlut.sv
// Quarter-wave sine magnitude ROM with a registered output.
// Entry i = round(127*sin((i+0.5)*pi/2^(LUT_AW+1))); the half-step offset
// makes the quarter table mirror cleanly without duplicating end points.
//   clk   : sample clock
//   rst_n : asynchronous active-low reset (clears the output register)
//   addr  : quarter-wave index
//   mag   : 7-bit magnitude, valid one clock after addr
module sine_qlut #(
    parameter int LUT_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW-1:0] addr,
    output logic [6:0]        mag
);

    localparam int  DEPTH = 2 ** LUT_AW;
    localparam real PI    = 3.14159265358979323846;

    // Elaboration-time sine via a Taylor series; the angle never exceeds
    // pi/2, where 12 terms are far more accurate than the 7-bit rounding.
    function automatic logic [6:0] sine_entry(input int i);
        real x;
        real term;
        real sum;
        x    = (real'(i) + 0.5) * PI / real'(2 ** (LUT_AW + 1));
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return 7'($rtoi(127.0 * sum + 0.5));
    endfunction

    logic [6:0] rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [6:0] ENTRY = sine_entry(gi);
        assign rom[gi] = ENTRY;
    end

    logic [6:0] mag_d;
    logic [6:0] mag_q;

    always_comb begin
        mag_d = rom[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign mag = mag_q;

endmodule

// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator for an 8-bit DAC.
// Pipeline: phase accumulator -> stage 1 (raw waveform code, sine ROM)
//           -> stage 2 (gain/offset/saturate) -> da_data.
// Settings are shadowed and only change at a period boundary, so a period
// is never distorted by a mid-period write.
//   ad_clk    : sample clock
//   rst_n     : asynchronous active-low reset
//   wave_en   : run enable; accumulator held at 0 while low
//   wave_sel  : 0 sine, 1 square, 2 triangle, 3 sawtooth, 4-7 DC
//   freq_word : phase increment per clock
//   amp       : gain, amp/128
//   offset    : output centre code
//   da_data   : output sample (offset shadow when no valid sample)
//   da_valid  : da_data carries a generated sample
//   cyc_sync  : marks the first sample of each period
module dds_wave_gen
    import dds_wave_gen_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8
) (
    input  logic               ad_clk,
    input  logic               rst_n,
    input  logic               wave_en,
    input  logic [2:0]         wave_sel,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [7:0]         amp,
    input  logic [7:0]         offset,
    output logic [7:0]         da_data,
    output logic               da_valid,
    output logic               cyc_sync
);

    localparam int MSB = PHASE_W - 1;

    // Shadow settings, accumulator and its bookkeeping
    logic [2:0]         sel_d,  sel_q;
    logic [PHASE_W-1:0] freq_d, freq_q;
    logic [7:0]         amp_d,  amp_q;
    logic [7:0]         off_d,  off_q;
    logic [PHASE_W-1:0] acc_d,  acc_q;
    logic               run_d,  run_q;
    logic               wrap_d, wrap_q;

    // Stage 1
    logic [7:0] raw_d,     raw_q;
    logic       sine_d,    sine_q;
    logic       neg_d,     neg_q;
    logic       v1_d,      v1_q;
    logic       sync1_d,   sync1_q;
    logic [7:0] amp1_d,    amp1_q;
    logic [7:0] off1_d,    off1_q;

    // Stage 2
    logic [7:0] data_d,    data_q;
    logic       v2_d,      v2_q;
    logic       sync2_d,   sync2_q;

    logic [PHASE_W-1:0] acc_sum;
    logic               carry;
    logic               s0_sync;
    logic [LUT_AW-1:0]  lut_addr;
    logic [6:0]         lut_mag;
    logic [7:0]         raw_s1;
    logic signed [16:0] diff_x;
    logic signed [16:0] gain_x;
    logic signed [16:0] prod;
    logic signed [16:0] sum;

    sine_qlut #(.LUT_AW(LUT_AW)) u_sine_qlut (
        .clk   (ad_clk),
        .rst_n (rst_n),
        .addr  (lut_addr),
        .mag   (lut_mag)
    );

    // Accumulator and shadow update
    always_comb begin
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, freq_q};
        acc_d  = wave_en ? acc_sum : '0;
        run_d  = wave_en;
        wrap_d = wave_en & carry;
        sel_d  = sel_q;
        freq_d = freq_q;
        amp_d  = amp_q;
        off_d  = off_q;
        if (!wave_en || carry) begin
            sel_d  = wave_sel;
            freq_d = freq_word;
            amp_d  = amp;
            off_d  = offset;
        end
        // Current acc is a period start if it follows a wrap or is the
        // held zero phase in the first enabled cycle.
        s0_sync = wave_en & (~run_q | wrap_q);
    end

    // Stage 1: raw waveform code; amp/offset travel with the sample so a
    // settings change at a wrap lines up with the first new-period sample.
    always_comb begin
        lut_addr = acc_q[MSB-1] ? ~acc_q[MSB-2 -: LUT_AW] : acc_q[MSB-2 -: LUT_AW];
        sine_d   = (sel_q == WAVE_SINE);
        neg_d    = acc_q[MSB];
        case (sel_q)
            WAVE_SAW:    raw_d = acc_q[MSB -: 8];
            WAVE_SQUARE: raw_d = acc_q[MSB] ? 8'd0 : 8'd255;
            WAVE_TRI:    raw_d = acc_q[MSB] ? ~acc_q[MSB-1 -: 8] : acc_q[MSB-1 -: 8];
            WAVE_SINE:   raw_d = MID_CODE;
            default:     raw_d = MID_CODE;
        endcase
        v1_d    = wave_en;
        sync1_d = s0_sync;
        amp1_d  = amp_q;
        off1_d  = off_q;
    end

    // Stage 2: gain, offset and clamp
    always_comb begin
        if (sine_q) begin
            raw_s1 = neg_q ? (MID_CODE - {1'b0, lut_mag}) : (MID_CODE + {1'b0, lut_mag});
        end else begin
            raw_s1 = raw_q;
        end
        diff_x  = $signed({9'd0, raw_s1}) - 17'sd128;
        gain_x  = $signed({9'd0, amp1_q});
        prod    = diff_x * gain_x;
        sum     = $signed({9'd0, off1_q}) + (prod >>> 7);
        data_d  = sat_u8(sum);
        v2_d    = v1_q;
        sync2_d = sync1_q & v1_q;
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= WAVE_SINE;
            freq_q  <= '0;
            amp_q   <= UNITY_GAMP;
            off_q   <= MID_CODE;
            acc_q   <= '0;
            run_q   <= 1'b0;
            wrap_q  <= 1'b0;
            raw_q   <= '0;
            sine_q  <= 1'b0;
            neg_q   <= 1'b0;
            v1_q    <= 1'b0;
            sync1_q <= 1'b0;
            amp1_q  <= '0;
            off1_q  <= '0;
            data_q  <= '0;
            v2_q    <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            off_q   <= off_d;
            acc_q   <= acc_d;
            run_q   <= run_d;
            wrap_q  <= wrap_d;
            raw_q   <= raw_d;
            sine_q  <= sine_d;
            neg_q   <= neg_d;
            v1_q    <= v1_d;
            sync1_q <= sync1_d;
            amp1_q  <= amp1_d;
            off1_q  <= off1_d;
            data_q  <= data_d;
            v2_q    <= v2_d;
            sync2_q <= sync2_d;
        end
    end

    assign da_data  = v2_q ? data_q : off_q;
    assign da_valid = v2_q;
    assign cyc_sync = sync2_q;

endmodule
